fetch_stage: RTL and testbench

//  Instruction fetch stage with IF/ID pipeline register, directly upstream of the control unit.

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_pc.sv | 25 ++
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - opcode and fetch FSM definitions shared by the fetch stage
package fetch_stage_pkg;

    localparam logic [3:0] OP_HALT  = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_BGT   = 4'b0100;
    localparam logic [3:0] OP_BLT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b0111;
    localparam logic [3:0] OP_LBU   = 4'b1010;
    localparam logic [3:0] OP_SB    = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_TYPEA = 4'b1111;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_WAIT = 2'd1,
        ST_HALTED    = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter register with reset/redirect/hold/+2 next-PC selection
module fetch_pc #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target,
    input  logic              hold,
    output logic [ADDR_W-1:0] pc
);

    // Instructions are halfword aligned, so bit 0 of any loaded PC is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= {RESET_PC[ADDR_W-1:1], 1'b0};
        end else if (redirect) begin
            pc <= {target[ADDR_W-1:1], 1'b0};
        end else if (!hold) begin
            pc <= pc + ADDR_W'(2);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with IF/ID register, stall, flush, redirect and HALT drain
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                INSTR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imemAddr,
    input  logic [INSTR_W-1:0] imemData,
    input  logic               stall,
    input  logic               redirectValid,
    input  logic [ADDR_W-1:0]  redirectTarget,
    output logic [INSTR_W-1:0] ifIdInstr,
    output logic [ADDR_W-1:0]  ifIdPcPlus2,
    output logic               ifIdValid,
    output logic               halted
);

    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    fetch_state_e      state;
    logic [CNT_W-1:0]  drain_cnt;
    logic [ADDR_W-1:0] pc;
    logic              is_halt;
    logic              redirect_en;
    logic              pc_hold;

    assign is_halt     = (imemData[INSTR_W-1 -: 4] == OP_HALT);
    // A frozen core ignores late redirects; only reset revives it.
    assign redirect_en = redirectValid && (state != ST_HALTED);
    assign pc_hold     = stall || (state != ST_RUN) || is_halt;
    assign imemAddr    = pc;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .redirect (redirect_en),
        .target   (redirectTarget),
        .hold     (pc_hold),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            ifIdInstr   <= '0;
            ifIdPcPlus2 <= '0;
            ifIdValid   <= 1'b0;
            halted      <= 1'b0;
        end else if (redirect_en) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            ifIdInstr <= '0;
            ifIdValid <= 1'b0;
        end else if (!(stall && state != ST_HALTED)) begin
            case (state)
                ST_RUN: begin
                    ifIdInstr   <= imemData;
                    ifIdPcPlus2 <= pc + ADDR_W'(2);
                    ifIdValid   <= 1'b1;
                    if (is_halt) begin
                        state     <= ST_HALT_WAIT;
                        drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                ST_HALT_WAIT: begin
                    ifIdInstr <= '0;
                    ifIdValid <= 1'b0;
                    if (drain_cnt == '0) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    ifIdInstr <= '0;
                    ifIdValid <= 1'b0;
                    halted    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic        stall;
    logic        redirectValid;
    logic [15:0] redirectTarget;
    logic [15:0] ifIdInstr;
    logic [15:0] ifIdPcPlus2;
    logic        ifIdValid;
    logic        halted;

    logic [15:0] mem [0:32767];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign imemData = mem[imemAddr[15:1]];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imemAddr       (imemAddr),
        .imemData       (imemData),
        .stall          (stall),
        .redirectValid  (redirectValid),
        .redirectTarget (redirectTarget),
        .ifIdInstr      (ifIdInstr),
        .ifIdPcPlus2    (ifIdPcPlus2),
        .ifIdValid      (ifIdValid),
        .halted         (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i] = {4'h1, i[11:0]};
        end
        mem[0] = 16'hF001;
        mem[1] = 16'h1234;
        mem[8] = 16'h0000;

        rst = 1'b1; stall = 1'b0; redirectValid = 1'b0; redirectTarget = 16'h0;
        step(); step();
        check("reset_addr",   imemAddr,    16'h0000);
        check("reset_instr",  ifIdInstr,   16'h0000);
        check("reset_pcp2",   ifIdPcPlus2, 16'h0000);
        check("reset_valid",  16'(ifIdValid), 16'h0);
        check("reset_halted", 16'(halted),    16'h0);

        // sequential fetch
        rst = 1'b0;
        step();
        check("seq1_instr", ifIdInstr,   16'hF001);
        check("seq1_pcp2",  ifIdPcPlus2, 16'h0002);
        check("seq1_valid", 16'(ifIdValid), 16'h1);
        check("seq1_addr",  imemAddr,    16'h0002);
        step();
        check("seq2_instr", ifIdInstr,   16'h1234);
        check("seq2_pcp2",  ifIdPcPlus2, 16'h0004);
        check("seq2_addr",  imemAddr,    16'h0004);

        // stall holds everything
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", ifIdInstr,   16'h1234);
            check("stall_pcp2",  ifIdPcPlus2, 16'h0004);
            check("stall_addr",  imemAddr,    16'h0004);
        end
        stall = 1'b0;
        step();
        check("resume_instr", ifIdInstr,   16'h1002);
        check("resume_pcp2",  ifIdPcPlus2, 16'h0006);
        check("resume_addr",  imemAddr,    16'h0006);

        // redirect beats stall
        redirectValid = 1'b1; redirectTarget = 16'h0040; stall = 1'b1;
        step();
        check("redir_addr",  imemAddr,        16'h0040);
        check("redir_valid", 16'(ifIdValid),  16'h0);
        check("redir_instr", ifIdInstr,       16'h0000);
        redirectValid = 1'b0; stall = 1'b0;
        step();
        check("redir_pcp2",  ifIdPcPlus2, 16'h0042);
        check("redir_instr2", ifIdInstr,  16'h1020);
        check("redir_valid2", 16'(ifIdValid), 16'h1);

        // redirect squashes a HALT fetched in the same cycle
        redirectValid = 1'b1; redirectTarget = 16'h0010;
        step();
        redirectTarget = 16'h0021;
        step();
        check("squash_addr",  imemAddr,       16'h0020);
        check("squash_valid", 16'(ifIdValid), 16'h0);
        redirectValid = 1'b0;
        step();
        check("squash_instr", ifIdInstr,    16'h1010);
        check("squash_halted", 16'(halted), 16'h0);

        // HALT drains to HALTED after DRAIN_CYCLES
        redirectValid = 1'b1; redirectTarget = 16'h0010;
        step();
        redirectValid = 1'b0;
        step();
        check("halt_instr", ifIdInstr,      16'h0000);
        check("halt_valid", 16'(ifIdValid), 16'h1);
        check("halt_pcp2",  ifIdPcPlus2,    16'h0012);
        check("halt_addr",  imemAddr,       16'h0010);
        check("halt_h0",    16'(halted),    16'h0);
        step();
        check("halt_bubble", 16'(ifIdValid), 16'h0);
        check("halt_h1",     16'(halted),    16'h0);
        step();
        check("halt_h2",     16'(halted),    16'h0);
        step();
        check("halt_h3",     16'(halted),    16'h1);
        check("halt_addr3",  imemAddr,       16'h0010);
        redirectValid = 1'b1; redirectTarget = 16'h0080; stall = 1'b1;
        step();
        redirectValid = 1'b0; stall = 1'b0;
        step();
        check("halted_ign_h",    16'(halted),    16'h1);
        check("halted_ign_addr", imemAddr,       16'h0010);
        check("halted_ign_v",    16'(ifIdValid), 16'h0);

        // reset out of HALTED, then HALT cancelled by redirect
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_addr",   imemAddr,       16'h0000);
        check("rst2_halted", 16'(halted),    16'h0);
        check("rst2_valid",  16'(ifIdValid), 16'h0);
        redirectValid = 1'b1; redirectTarget = 16'h0010;
        step();
        redirectValid = 1'b0;
        step();
        check("hw_instr", ifIdInstr, 16'h0000);
        step();
        redirectValid = 1'b1; redirectTarget = 16'h0080;
        step();
        redirectValid = 1'b0;
        check("hw_redir_addr", imemAddr,       16'h0080);
        check("hw_redir_h",    16'(halted),    16'h0);
        check("hw_redir_v",    16'(ifIdValid), 16'h0);
        step();
        check("hw_resume_instr", ifIdInstr,    16'h1040);
        check("hw_resume_pcp2",  ifIdPcPlus2,  16'h0082);
        check("hw_resume_addr",  imemAddr,     16'h0082);
        for (int i = 0; i < 4; i++) step();
        check("hw_never_halted", 16'(halted), 16'h0);

        // wrap at top of address space
        redirectValid = 1'b1; redirectTarget = 16'hFFFE;
        step();
        redirectValid = 1'b0;
        check("wrap_pre_addr", imemAddr, 16'hFFFE);
        step();
        check("wrap_instr", ifIdInstr,   16'h1FFF);
        check("wrap_pcp2",  ifIdPcPlus2, 16'h0000);
        check("wrap_addr",  imemAddr,    16'h0000);

        // reach HALTED again, then reset
        redirectValid = 1'b1; redirectTarget = 16'h0010;
        step();
        redirectValid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("halt2_h", 16'(halted), 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst3_addr",   imemAddr,       16'h0000);
        check("rst3_halted", 16'(halted),    16'h0);
        check("rst3_valid",  16'(ifIdValid), 16'h0);
        check("rst3_instr",  ifIdInstr,      16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
